// File: rtl/wb_arbiter2_pkg.sv
// Shared encodings for the two-master Wishbone arbiter and its watchdog.
// Grant encodings are one-hot so the state register drives grant_o directly.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'b00,
    GRANT_M0   = 2'b01,
    GRANT_M1   = 2'b10
  } grant_t;

  localparam int WB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts enabled cycles and pulses expire for one cycle at TIMEOUT.
// Expire is a decode of the registered count; the counter clears on expire or clear.
module wb_watchdog
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;

  assign expire_o = (wd_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || expire_o) begin
      wd_cnt <= '0;
    end else if (en_i) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with a hung-slave watchdog.
// Grant registers one cycle after cyc_i; the bus mux decodes combinationally from the grant.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int ADR_WIDTH = 64,
  parameter int DAT_WIDTH = 64,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int TIMEOUT   = WB_TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [SEL_WIDTH-1:0] m0_sel_i,
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic [DAT_WIDTH-1:0] m0_dat_i,
  output logic [DAT_WIDTH-1:0] m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [SEL_WIDTH-1:0] m1_sel_i,
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [DAT_WIDTH-1:0] m1_dat_i,
  output logic [DAT_WIDTH-1:0] m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [SEL_WIDTH-1:0] s_sel_o,
  output logic [ADR_WIDTH-1:0] s_adr_o,
  output logic [DAT_WIDTH-1:0] s_dat_o,
  input  logic [DAT_WIDTH-1:0] s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  output logic [1:0]           grant_o
);

  grant_t grant, grant_nxt;
  logic   last_owner, last_owner_nxt;
  logic   wd_en, wd_clr, wd_expire, wd_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant      <= GRANT_IDLE;
      last_owner <= 1'b1;
    end else begin
      grant      <= grant_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // No preemption: an owner keeps the bus until it drops cyc, even across watchdog errors.
  always_comb begin
    grant_nxt      = grant;
    last_owner_nxt = last_owner;
    case (grant)
      GRANT_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) grant_nxt = last_owner ? GRANT_M0 : GRANT_M1;
        else if (m0_cyc_i)        grant_nxt = GRANT_M0;
        else if (m1_cyc_i)        grant_nxt = GRANT_M1;
      end
      GRANT_M0: begin
        if (!m0_cyc_i) begin
          last_owner_nxt = 1'b0;
          grant_nxt      = m1_cyc_i ? GRANT_M1 : GRANT_IDLE;
        end
      end
      GRANT_M1: begin
        if (!m1_cyc_i) begin
          last_owner_nxt = 1'b1;
          grant_nxt      = m0_cyc_i ? GRANT_M0 : GRANT_IDLE;
        end
      end
      default: grant_nxt = GRANT_IDLE;
    endcase
  end

  assign grant_o = grant;

  // An ack landing on the expiry cycle means the slave did answer, so it suppresses the error.
  assign wd_err = wd_expire && !s_ack_i;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (grant)
      GRANT_M0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i && m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || wd_err;
      end
      GRANT_M1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i && m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || wd_err;
      end
      default: ;
    endcase
  end

  assign wd_en  = s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;
  assign wd_clr = !(s_cyc_o && s_stb_o) || s_ack_i || s_err_i || (grant_nxt != grant);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (wd_en),
    .clr_i    (wd_clr),
    .expire_o (wd_expire)
  );

endmodule
